add_rs_dispatch: RTL and testbench

- Add/sub reservation station and issue side of the add execution-unit interface.
- Holds up to 3 pending ADD/SUB ops from decode and snoops the CDB for missing operands.
- Dispatches the oldest fully-ready op to the add exec unit with a one-cycle ex_b strobe.
- Frees the entry when the exec unit reports completion. Sits between the decode/issue stage and the add exec unit.

---
 rtl/add_rs_dispatch.sv | 264 ++++++++++++++++++++++++++
 tb/tb_add_rs_dispatch.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_rs_dispatch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | add_rs_dispatch: 3-entry ADD/SUB reservation station with CDB snoop and    |
// | oldest-ready dispatch to the add exec unit. Option macro: BYPASS_EN.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module add_rs_dispatch #(
  parameter int DW   = 8,
  parameter int NENT = 3,
  parameter int TW   = 3
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          issue_valid,
  output logic          issue_ready,
  input  logic [3:0]    issue_func,
  input  logic [3:0]    issue_rd,
  input  logic [TW-1:0] issue_rob,
  input  logic          issue_q1_rdy,
  input  logic          issue_q2_rdy,
  input  logic [TW-1:0] issue_q1_tag,
  input  logic [TW-1:0] issue_q2_tag,
  input  logic [DW-1:0] issue_v1,
  input  logic [DW-1:0] issue_v2,
  input  logic          cdb_valid,
  input  logic [TW-1:0] cdb_tag,
  input  logic [DW-1:0] cdb_data,
  output logic          ex_b,
  output logic [2:0]    rs_index,
  output logic [DW-1:0] rs1_data,
  output logic [DW-1:0] rs2_data,
  output logic [3:0]    func,
  output logic [TW-1:0] rob_ind,
  output logic [3:0]    rd,
  input  logic          exec_done,
  input  logic [2:0]    exec_done_idx,
  output logic [1:0]    addcount
);

  localparam int         IW      = 3;
  localparam logic [1:0] S_FREE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;
  localparam logic [1:0] S_EXEC  = 2'd3;
  localparam logic [1:0] AGE_MAX = 2'd2;

  typedef struct packed {
    logic [1:0]    st;
    logic [1:0]    age;
    logic [3:0]    func;
    logic [3:0]    rd;
    logic [TW-1:0] rob;
    logic          q1_rdy;
    logic [TW-1:0] q1_tag;
    logic [DW-1:0] v1;
    logic          q2_rdy;
    logic [TW-1:0] q2_tag;
    logic [DW-1:0] v2;
  } entry_t;

  entry_t          r_ent     [NENT];
  entry_t          w_ent_nxt [NENT];
  logic            r_busy;
  logic            r_ex_b;
  logic [IW-1:0]   r_rs_index;
  logic [DW-1:0]   r_rs1_data;
  logic [DW-1:0]   r_rs2_data;
  logic [3:0]      r_func;
  logic [TW-1:0]   r_rob_ind;
  logic [3:0]      r_rd;
  logic [1:0]      r_addcount;

  logic            w_any_free;
  logic [IW-1:0]   w_alloc_idx;
  logic            w_issue_ready;
  logic            w_issue_fire;
  logic            w_in_q1_rdy;
  logic            w_in_q2_rdy;
  logic [DW-1:0]   w_in_v1;
  logic [DW-1:0]   w_in_v2;
  logic            w_disp_any;
  logic            w_disp_fire;
  logic [IW-1:0]   w_disp_idx;
  logic [1:0]      w_disp_age;
  logic [DW-1:0]   w_disp_v1;
  logic [DW-1:0]   w_disp_v2;
  logic [3:0]      w_disp_func;
  logic [TW-1:0]   w_disp_rob;
  logic [3:0]      w_disp_rd;
  logic [NENT-1:0] w_done_vec;
  logic            w_done_any;
  logic [1:0]      w_done_age;
  logic [1:0]      w_count_nxt;
  logic [2:0]      w_age_tmp;

`ifdef BYPASS_EN
  assign w_issue_ready = w_any_free;
  assign w_in_q1_rdy   = issue_q1_rdy | (cdb_valid & (cdb_tag == issue_q1_tag));
  assign w_in_q2_rdy   = issue_q2_rdy | (cdb_valid & (cdb_tag == issue_q2_tag));
  assign w_in_v1       = issue_q1_rdy ? issue_v1 : cdb_data;
  assign w_in_v2       = issue_q2_rdy ? issue_v2 : cdb_data;
`else
  // Issue is held off during a broadcast so no op can miss its producer's result.
  assign w_issue_ready = w_any_free & ~cdb_valid;
  assign w_in_q1_rdy   = issue_q1_rdy;
  assign w_in_q2_rdy   = issue_q2_rdy;
  assign w_in_v1       = issue_v1;
  assign w_in_v2       = issue_v2;
`endif

  assign w_issue_fire = issue_valid & w_issue_ready;
  assign w_disp_fire  = w_disp_any & ~r_busy;

  // Allocation, oldest-ready selection and completion match, all from registered state.
  always_comb begin : p_select
    w_any_free  = 1'b0;
    w_alloc_idx = '0;
    w_disp_any  = 1'b0;
    w_disp_idx  = '0;
    w_disp_age  = '0;
    w_disp_v1   = '0;
    w_disp_v2   = '0;
    w_disp_func = '0;
    w_disp_rob  = '0;
    w_disp_rd   = '0;
    w_done_vec  = '0;
    w_done_any  = 1'b0;
    w_done_age  = '0;
    for (int i = NENT - 1; i >= 0; i--) begin
      if (r_ent[i].st == S_FREE) begin
        w_any_free  = 1'b1;
        w_alloc_idx = IW'(i);
      end
    end
    for (int i = 0; i < NENT; i++) begin
      if (r_ent[i].st == S_READY && (!w_disp_any || r_ent[i].age > w_disp_age)) begin
        w_disp_any  = 1'b1;
        w_disp_idx  = IW'(i);
        w_disp_age  = r_ent[i].age;
        w_disp_v1   = r_ent[i].v1;
        w_disp_v2   = r_ent[i].v2;
        w_disp_func = r_ent[i].func;
        w_disp_rob  = r_ent[i].rob;
        w_disp_rd   = r_ent[i].rd;
      end
      if (exec_done && exec_done_idx == IW'(i) && r_ent[i].st == S_EXEC) begin
        w_done_vec[i] = 1'b1;
        w_done_any    = 1'b1;
        w_done_age    = r_ent[i].age;
      end
    end
  end

  always_comb begin : p_next
    w_count_nxt = '0;
    w_age_tmp   = '0;
    for (int i = 0; i < NENT; i++) begin
      w_ent_nxt[i] = r_ent[i];
      case (r_ent[i].st)
        S_FREE: begin
          if (w_issue_fire && w_alloc_idx == IW'(i)) begin
            w_ent_nxt[i].st     = (w_in_q1_rdy && w_in_q2_rdy) ? S_READY : S_WAIT;
            w_ent_nxt[i].age    = '0;
            w_ent_nxt[i].func   = issue_func;
            w_ent_nxt[i].rd     = issue_rd;
            w_ent_nxt[i].rob    = issue_rob;
            w_ent_nxt[i].q1_rdy = w_in_q1_rdy;
            w_ent_nxt[i].q1_tag = issue_q1_tag;
            w_ent_nxt[i].v1     = w_in_v1;
            w_ent_nxt[i].q2_rdy = w_in_q2_rdy;
            w_ent_nxt[i].q2_tag = issue_q2_tag;
            w_ent_nxt[i].v2     = w_in_v2;
          end
        end
        S_WAIT: begin
          if (!r_ent[i].q1_rdy && cdb_valid && cdb_tag == r_ent[i].q1_tag) begin
            w_ent_nxt[i].q1_rdy = 1'b1;
            w_ent_nxt[i].v1     = cdb_data;
          end
          if (!r_ent[i].q2_rdy && cdb_valid && cdb_tag == r_ent[i].q2_tag) begin
            w_ent_nxt[i].q2_rdy = 1'b1;
            w_ent_nxt[i].v2     = cdb_data;
          end
          if (w_ent_nxt[i].q1_rdy && w_ent_nxt[i].q2_rdy) begin
            w_ent_nxt[i].st = S_READY;
          end
        end
        S_READY: begin
          if (w_disp_fire && w_disp_idx == IW'(i)) begin
            w_ent_nxt[i].st = S_EXEC;
          end
        end
        default: begin
          if (w_done_vec[i]) begin
            w_ent_nxt[i].st  = S_FREE;
            w_ent_nxt[i].age = '0;
          end
        end
      endcase
      // Surviving entries age on every issue and close the gap left by a freed elder.
      if (r_ent[i].st != S_FREE && !w_done_vec[i]) begin
        w_age_tmp = {1'b0, r_ent[i].age};
        if (w_issue_fire) begin
          w_age_tmp = w_age_tmp + 3'd1;
        end
        if (w_done_any && r_ent[i].age > w_done_age) begin
          w_age_tmp = w_age_tmp - 3'd1;
        end
        w_ent_nxt[i].age = (w_age_tmp > {1'b0, AGE_MAX}) ? AGE_MAX : w_age_tmp[1:0];
      end
      if (w_ent_nxt[i].st != S_FREE) begin
        w_count_nxt = w_count_nxt + 2'd1;
      end
    end
  end

  always_ff @(posedge clk1) begin : p_state
    if (rst) begin
      for (int i = 0; i < NENT; i++) begin
        r_ent[i] <= '0;
      end
      r_busy     <= 1'b0;
      r_ex_b     <= 1'b0;
      r_rs_index <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_func     <= '0;
      r_rob_ind  <= '0;
      r_rd       <= '0;
      r_addcount <= '0;
    end else begin
      for (int i = 0; i < NENT; i++) begin
        r_ent[i] <= w_ent_nxt[i];
      end
      r_addcount <= w_count_nxt;
      r_ex_b     <= w_disp_fire;
      if (w_disp_fire) begin
        r_busy     <= 1'b1;
        r_rs_index <= w_disp_idx;
        r_rs1_data <= w_disp_v1;
        r_rs2_data <= w_disp_v2;
        r_func     <= w_disp_func;
        r_rob_ind  <= w_disp_rob;
        r_rd       <= w_disp_rd;
      end else if (w_done_any) begin
        r_busy <= 1'b0;
      end
    end
  end

  always_comb begin : p_out
    issue_ready = w_issue_ready;
    ex_b        = r_ex_b;
    rs_index    = r_rs_index;
    rs1_data    = r_rs1_data;
    rs2_data    = r_rs2_data;
    func        = r_func;
    rob_ind     = r_rob_ind;
    rd          = r_rd;
    addcount    = r_addcount;
  end

endmodule
`default_nettype wire

// File: tb/tb_add_rs_dispatch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_add_rs_dispatch: self-checking bench for add_rs_dispatch.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_add_rs_dispatch;

  logic       clk1 = 1'b0;
  logic       rst;
  logic       issue_valid;
  logic       issue_ready;
  logic [3:0] issue_func;
  logic [3:0] issue_rd;
  logic [2:0] issue_rob;
  logic       issue_q1_rdy;
  logic       issue_q2_rdy;
  logic [2:0] issue_q1_tag;
  logic [2:0] issue_q2_tag;
  logic [7:0] issue_v1;
  logic [7:0] issue_v2;
  logic       cdb_valid;
  logic [2:0] cdb_tag;
  logic [7:0] cdb_data;
  logic       ex_b;
  logic [2:0] rs_index;
  logic [7:0] rs1_data;
  logic [7:0] rs2_data;
  logic [3:0] func;
  logic [2:0] rob_ind;
  logic [3:0] rd;
  logic       exec_done;
  logic [2:0] exec_done_idx;
  logic [1:0] addcount;

  add_rs_dispatch #(.DW(8), .NENT(3), .TW(3)) dut (
    .clk1(clk1), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_func(issue_func), .issue_rd(issue_rd), .issue_rob(issue_rob),
    .issue_q1_rdy(issue_q1_rdy), .issue_q2_rdy(issue_q2_rdy),
    .issue_q1_tag(issue_q1_tag), .issue_q2_tag(issue_q2_tag),
    .issue_v1(issue_v1), .issue_v2(issue_v2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .ex_b(ex_b), .rs_index(rs_index), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .func(func), .rob_ind(rob_ind), .rd(rd),
    .exec_done(exec_done), .exec_done_idx(exec_done_idx), .addcount(addcount)
  );

  always #5 clk1 = ~clk1;

  typedef struct {
    logic [2:0] idx;
    logic [7:0] rs1;
    logic [7:0] rs2;
    logic [3:0] func;
    logic [2:0] rob;
    logic [3:0] rd;
  } disp_t;

  typedef struct {
    logic [3:0] func;
    logic [3:0] rd;
    logic [2:0] rob;
    logic [7:0] v1;
    logic [7:0] v2;
    logic [2:0] e_idx;
    logic [7:0] e_rs1;
    logic [7:0] e_rs2;
  } vec_t;

  disp_t exp_q[$];
  vec_t  vt[4];
  int    errors    = 0;
  int    checks    = 0;
  int    disp_cnt  = 0;
  int    nd        = 0;
  logic  prev_ex_b = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and score any dispatch strobe seen there.
  task automatic step();
    disp_t e;
    @(negedge clk1);
    if (ex_b === 1'b1) begin
      disp_cnt++;
      chk("ex_b_single_pulse", 32'(prev_ex_b), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ex_b: got ex_b=1 rs_index=%0d, want no dispatch", rs_index);
      end else begin
        e = exp_q.pop_front();
        chk("rs_index", 32'(rs_index), 32'(e.idx));
        chk("rs1_data", 32'(rs1_data), 32'(e.rs1));
        chk("rs2_data", 32'(rs2_data), 32'(e.rs2));
        chk("func",     32'(func),     32'(e.func));
        chk("rob_ind",  32'(rob_ind),  32'(e.rob));
        chk("rd",       32'(rd),       32'(e.rd));
      end
    end
    prev_ex_b = (ex_b === 1'b1);
  endtask

  task automatic wait_disp(input int target, input string name);
    int n;
    n = 0;
    while (disp_cnt < target && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (disp_cnt < target) begin
      errors++;
      $display("FAIL %s: dispatch count %0d, want %0d", name, disp_cnt, target);
    end
  endtask

  task automatic drive_issue(input logic [3:0] f, input logic [3:0] d, input logic [2:0] rob,
                             input logic q1r, input logic [2:0] t1, input logic [7:0] v1,
                             input logic q2r, input logic [2:0] t2, input logic [7:0] v2);
    issue_valid  = 1'b1;
    issue_func   = f;
    issue_rd     = d;
    issue_rob    = rob;
    issue_q1_rdy = q1r;
    issue_q1_tag = t1;
    issue_v1     = v1;
    issue_q2_rdy = q2r;
    issue_q2_tag = t2;
    issue_v2     = v2;
  endtask

  task automatic push_exp(input logic [2:0] idx, input logic [7:0] r1, input logic [7:0] r2,
                          input logic [3:0] f, input logic [2:0] rob, input logic [3:0] d);
    disp_t e;
    e.idx = idx; e.rs1 = r1; e.rs2 = r2; e.func = f; e.rob = rob; e.rd = d;
    exp_q.push_back(e);
  endtask

  task automatic done(input logic [2:0] idx);
    exec_done     = 1'b1;
    exec_done_idx = idx;
    step();
    exec_done     = 1'b0;
  endtask

  task automatic pulse_cdb(input logic [2:0] tag, input logic [7:0] data);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_data  = data;
    step();
    cdb_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_func = '0; issue_rd = '0; issue_rob = '0;
    issue_q1_rdy = 1'b0; issue_q2_rdy = 1'b0; issue_q1_tag = '0; issue_q2_tag = '0;
    issue_v1 = '0; issue_v2 = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    exec_done = 1'b0; exec_done_idx = '0;

    vt[0] = '{4'h0, 4'h2, 3'd1, 8'h05, 8'h03, 3'd0, 8'h05, 8'h03};
    vt[1] = '{4'h1, 4'h7, 3'd3, 8'h40, 8'h11, 3'd0, 8'h40, 8'h11};
    vt[2] = '{4'hA, 4'hF, 3'd7, 8'hFF, 8'h00, 3'd0, 8'hFF, 8'h00};
    vt[3] = '{4'h0, 4'h0, 3'd0, 8'h80, 8'h7F, 3'd0, 8'h80, 8'h7F};

    repeat (3) step();
    chk("rst_ex_b", 32'(ex_b), 32'd0);
    chk("rst_addcount", 32'(addcount), 32'd0);
    chk("rst_rs_index", 32'(rs_index), 32'd0);
    chk("rst_rs1_data", 32'(rs1_data), 32'd0);
    chk("rst_rs2_data", 32'(rs2_data), 32'd0);
    chk("rst_func", 32'(func), 32'd0);
    chk("rst_rob_ind", 32'(rob_ind), 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    rst = 1'b0;
    #1 chk("rst_issue_ready", 32'(issue_ready), 32'd1);

    // Single ready ops: two-edge latency to ex_b, then completion frees entry 0.
    for (int k = 0; k < 4; k++) begin
      drive_issue(vt[k].func, vt[k].rd, vt[k].rob, 1'b1, 3'd0, vt[k].v1, 1'b1, 3'd0, vt[k].v2);
      #1 chk("vec_issue_ready", 32'(issue_ready), 32'd1);
      push_exp(vt[k].e_idx, vt[k].e_rs1, vt[k].e_rs2, vt[k].func, vt[k].rob, vt[k].rd);
      step();
      issue_valid = 1'b0;
      chk("vec_ex_b_not_yet", 32'(ex_b), 32'd0);
      chk("vec_addcount_1", 32'(addcount), 32'd1);
      nd++;
      step();
      chk("vec_ex_b_latency", 32'(ex_b), 32'd1);
      wait_disp(nd, "vec_dispatch");
      done(3'd0);
      chk("vec_addcount_0", 32'(addcount), 32'd0);
    end

    // SUB waiting on tag 5; a non-matching broadcast must not wake it.
    drive_issue(4'h1, 4'h4, 3'd2, 1'b0, 3'd5, 8'h00, 1'b1, 3'd0, 8'h01);
    step();
    issue_valid = 1'b0;
    chk("wait_addcount", 32'(addcount), 32'd1);
    pulse_cdb(3'd3, 8'hEE);
    step(); step();
    chk("wait_no_dispatch", 32'(disp_cnt), 32'(nd));
    push_exp(3'd0, 8'h09, 8'h01, 4'h1, 3'd2, 4'h4);
    pulse_cdb(3'd5, 8'h09);
    nd++;
    wait_disp(nd, "cdb_dispatch");
    done(3'd0);

    // Both operands captured from one broadcast.
    drive_issue(4'h0, 4'h5, 3'd3, 1'b0, 3'd6, 8'h00, 1'b0, 3'd6, 8'h00);
    step();
    issue_valid = 1'b0;
    push_exp(3'd0, 8'h3C, 8'h3C, 4'h0, 3'd3, 4'h5);
    pulse_cdb(3'd6, 8'h3C);
    nd++;
    wait_disp(nd, "dual_capture_dispatch");
    done(3'd0);

    // Fill all three entries; then age must beat index when entry 0 is reused.
    drive_issue(4'h0, 4'h1, 3'd4, 1'b1, 3'd0, 8'h11, 1'b1, 3'd0, 8'h22);
    push_exp(3'd0, 8'h11, 8'h22, 4'h0, 3'd4, 4'h1);
    step();
    drive_issue(4'h1, 4'h2, 3'd5, 1'b1, 3'd0, 8'h33, 1'b1, 3'd0, 8'h44);
    push_exp(3'd1, 8'h33, 8'h44, 4'h1, 3'd5, 4'h2);
    step();
    drive_issue(4'h0, 4'h3, 3'd6, 1'b1, 3'd0, 8'h55, 1'b1, 3'd0, 8'h66);
    push_exp(3'd2, 8'h55, 8'h66, 4'h0, 3'd6, 4'h3);
    step();
    issue_valid = 1'b0;
    nd++;
    chk("full_dispatch_a", 32'(disp_cnt), 32'(nd));
    chk("full_addcount", 32'(addcount), 32'd3);
    #1 chk("full_issue_ready", 32'(issue_ready), 32'd0);
    drive_issue(4'h0, 4'h6, 3'd7, 1'b1, 3'd0, 8'h77, 1'b1, 3'd0, 8'h88);
    exec_done = 1'b1;
    exec_done_idx = 3'd0;
    #1 chk("free_and_issue_ready", 32'(issue_ready), 32'd0);
    step();
    exec_done = 1'b0;
    chk("freed_not_reused", 32'(addcount), 32'd2);
    push_exp(3'd0, 8'h77, 8'h88, 4'h0, 3'd7, 4'h6);
    step();
    issue_valid = 1'b0;
    chk("refill_addcount", 32'(addcount), 32'd3);
    nd++;
    wait_disp(nd, "age_dispatch_b");
    done(3'd1);
    nd++;
    wait_disp(nd, "age_dispatch_c");
    done(3'd2);
    nd++;
    wait_disp(nd, "age_dispatch_d");
    done(3'd0);
    chk("age_drain_addcount", 32'(addcount), 32'd0);

    // Completion naming an entry that is not executing is ignored.
    drive_issue(4'h0, 4'h1, 3'd1, 1'b1, 3'd0, 8'h01, 1'b1, 3'd0, 8'h02);
    push_exp(3'd0, 8'h01, 8'h02, 4'h0, 3'd1, 4'h1);
    step();
    issue_valid = 1'b0;
    nd++;
    wait_disp(nd, "busy_dispatch_e");
    drive_issue(4'h1, 4'h2, 3'd2, 1'b1, 3'd0, 8'h03, 1'b1, 3'd0, 8'h04);
    push_exp(3'd1, 8'h03, 8'h04, 4'h1, 3'd2, 4'h2);
    step();
    issue_valid = 1'b0;
    done(3'd1);
    step(); step(); step();
    chk("bad_done_addcount", 32'(addcount), 32'd2);
    chk("bad_done_no_dispatch", 32'(disp_cnt), 32'(nd));
    done(3'd0);
    nd++;
    wait_disp(nd, "busy_dispatch_f");
    done(3'd1);
    chk("bad_done_drain", 32'(addcount), 32'd0);

    // Issue racing a broadcast on the operand's own tag.
    drive_issue(4'h0, 4'h9, 3'd2, 1'b0, 3'd4, 8'h00, 1'b1, 3'd0, 8'h10);
    cdb_valid = 1'b1;
    cdb_tag   = 3'd4;
    cdb_data  = 8'h22;
`ifdef BYPASS_EN
    #1 chk("bypass_issue_ready", 32'(issue_ready), 32'd1);
    push_exp(3'd0, 8'h22, 8'h10, 4'h0, 3'd2, 4'h9);
    step();
    issue_valid = 1'b0;
    cdb_valid = 1'b0;
    chk("bypass_addcount", 32'(addcount), 32'd1);
`else
    #1 chk("nobypass_issue_ready", 32'(issue_ready), 32'd0);
    step();
    cdb_valid = 1'b0;
    chk("nobypass_held", 32'(addcount), 32'd0);
    #1 chk("nobypass_ready_after", 32'(issue_ready), 32'd1);
    step();
    issue_valid = 1'b0;
    chk("nobypass_accepted", 32'(addcount), 32'd1);
    push_exp(3'd0, 8'h22, 8'h10, 4'h0, 3'd2, 4'h9);
    pulse_cdb(3'd4, 8'h22);
`endif
    nd++;
    wait_disp(nd, "race_dispatch");
    done(3'd0);

    // Reset while a dispatch decision is in flight.
    drive_issue(4'h0, 4'h1, 3'd1, 1'b1, 3'd0, 8'hAA, 1'b1, 3'd0, 8'hBB);
    step();
    issue_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_inflight_ex_b", 32'(ex_b), 32'd0);
    chk("rst_inflight_addcount", 32'(addcount), 32'd0);
    step(); step();
    chk("rst_inflight_no_dispatch", 32'(disp_cnt), 32'(nd));

    // Reset while an entry executes; the late completion must change nothing.
    drive_issue(4'h1, 4'h3, 3'd5, 1'b1, 3'd0, 8'h12, 1'b1, 3'd0, 8'h34);
    push_exp(3'd0, 8'h12, 8'h34, 4'h1, 3'd5, 4'h3);
    step();
    issue_valid = 1'b0;
    nd++;
    wait_disp(nd, "pre_reset_dispatch");
    rst = 1'b1;
    step();
    rst = 1'b0;
    done(3'd0);
    step(); step();
    chk("rst_exec_addcount", 32'(addcount), 32'd0);
    chk("rst_exec_ex_b", 32'(ex_b), 32'd0);
    chk("rst_exec_no_dispatch", 32'(disp_cnt), 32'(nd));
    drive_issue(4'h0, 4'h8, 3'd6, 1'b1, 3'd0, 8'h5A, 1'b1, 3'd0, 8'hA5);
    push_exp(3'd0, 8'h5A, 8'hA5, 4'h0, 3'd6, 4'h8);
    step();
    issue_valid = 1'b0;
    nd++;
    wait_disp(nd, "post_reset_dispatch");
    done(3'd0);
    chk("post_reset_addcount", 32'(addcount), 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
